// File: rtl/xintf_master.sv
// Initiator for a 16-bit async external bus: single read/write cycles with
// programmable lead/active/trail timing and an optional ready-wait with timeout.
module xintf_master #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned LEAD      = 2,
  parameter int unsigned ACTIVE    = 4,
  parameter int unsigned TRAIL     = 1,
  parameter int unsigned USE_READY = 1,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk_i,
  input  logic              global_rst_i,
  input  logic              req_i,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              timeout_err_o,
  output logic [ADDR_W-1:0] xadd_o,
  inout  wire  [DATA_W-1:0] xdata_io,
  output logic              xcs_n_o,
  output logic              xwe_n_o,
  output logic              xrd_n_o,
  input  logic              xready_i
);

  typedef enum logic [2:0] {StIdle, StLead, StActive, StWait, StTrail} state_e;

  localparam logic [7:0] LeadLd    = 8'(LEAD - 1);
  localparam logic [7:0] ActiveLd  = 8'(ACTIVE - 1);
  localparam logic [7:0] TrailLd   = 8'(TRAIL - 1);
  localparam logic [7:0] TimeoutLd = 8'(TIMEOUT - 1);
  localparam logic       ReadyEn   = (USE_READY != 0);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   xadd_q, xadd_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                terr_q, terr_d;
  logic                xcs_n_q, xcs_n_d;
  logic                xwe_n_q, xwe_n_d;
  logic                xrd_n_q, xrd_n_d;
  logic                drive_q, drive_d;
  logic                strobe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    xadd_d  = xadd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d = StLead;
          cnt_d   = LeadLd;
          we_d    = req_we_i;
          xadd_d  = req_addr_i;
          wdata_d = req_wdata_i;
          err_d   = 1'b0;
        end
      end
      StLead: begin
        if (cnt_q == 8'd0) begin
          state_d = StActive;
          cnt_d   = ActiveLd;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StActive: begin
        if (cnt_q == 8'd0) begin
          if (ReadyEn && !xready_i) begin
            state_d = StWait;
            cnt_d   = TimeoutLd;
          end else begin
            state_d = StTrail;
            cnt_d   = TrailLd;
            if (!we_q) rdata_d = xdata_io;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StWait: begin
        // Ready on the final wait edge still wins over the timeout.
        if (xready_i) begin
          state_d = StTrail;
          cnt_d   = TrailLd;
          if (!we_q) rdata_d = xdata_io;
        end else if (cnt_q == 8'd0) begin
          state_d = StTrail;
          cnt_d   = TrailLd;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StTrail: begin
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bus outputs follow the next state so they change on the same edge as the state.
    strobe_d = (state_d == StActive) || (state_d == StWait);
    busy_d   = (state_d != StIdle);
    xcs_n_d  = (state_d == StIdle);
    xwe_n_d  = !(strobe_d && we_d);
    xrd_n_d  = !(strobe_d && !we_d);
    drive_d  = we_d && (state_d != StIdle);
    terr_d   = done_d && err_d;
  end

  always_ff @(posedge clk_i) begin
    if (global_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      xadd_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      xcs_n_q <= 1'b1;
      xwe_n_q <= 1'b1;
      xrd_n_q <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      xadd_q  <= xadd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      xcs_n_q <= xcs_n_d;
      xwe_n_q <= xwe_n_d;
      xrd_n_q <= xrd_n_d;
      drive_q <= drive_d;
    end
  end

  assign xdata_io      = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign rdata_o       = rdata_q;
  assign timeout_err_o = terr_q;
  assign xadd_o        = xadd_q;
  assign xcs_n_o       = xcs_n_q;
  assign xwe_n_o       = xwe_n_q;
  assign xrd_n_o       = xrd_n_q;

endmodule

// File: tb/tb_xintf_master.sv
// Bench for xintf_master: transaction-level timing model checked every cycle,
// plus directed scenarios with hand-computed cycle counts.
module tb_xintf_master;

  localparam int L = 2, A = 4, T = 1, TO = 16;

  logic        clk;
  logic        rst, req, req_we, xready;
  logic [19:0] req_addr;
  logic [15:0] req_wdata, pdata;
  logic        busy, done, terr, xcs_n, xwe_n, xrd_n;
  logic [15:0] rdata;
  logic [19:0] xadd;
  wire  [15:0] xdata;

  // Peripheral drives read data only while the read strobe is low.
  assign xdata = xrd_n ? 16'hzzzz : pdata;

  xintf_master dut (
    .clk_i        (clk),
    .global_rst_i (rst),
    .req_i        (req),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .busy_o       (busy),
    .done_o       (done),
    .rdata_o      (rdata),
    .timeout_err_o(terr),
    .xadd_o       (xadd),
    .xdata_io     (xdata),
    .xcs_n_o      (xcs_n),
    .xwe_n_o      (xwe_n),
    .xrd_n_o      (xrd_n),
    .xready_i     (xready)
  );

  int cyc = 0;
  int checks = 0, errors = 0;
  int rl_lo = 0, rl_hi = 0;
  bit mon_en = 0;

  // Model: one transaction record described by its accept cycle and total length.
  bit          m_act = 0, m_we = 0, m_err = 0;
  int          m_acc = 0, m_w = 0, m_d = 0;
  logic [19:0] m_addr = '0;
  logic [15:0] m_wdata = '0, m_rdata = '0;

  int cs_low, we_low, rd_low, done_cnt, done_cyc, first_done;
  logic        done_terr;
  logic [15:0] done_rdata;
  int acc;

  function automatic bit ready_fn(int c);
    return !(c >= rl_lo && c < rl_hi);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_meas();
    cs_low = 0; we_low = 0; rd_low = 0; done_cnt = 0; done_cyc = 0; first_done = 0;
    done_terr = 0; done_rdata = '0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && done_cnt == 0; i++) tick();
    chk("done_seen", 32'(done_cnt > 0), 1);
  endtask

  task automatic do_txn(input bit we, input logic [19:0] a, input logic [15:0] d);
    clear_meas();
    req = 1; req_we = we; req_addr = a; req_wdata = d;
    acc = cyc;
    tick();
    req = 0;
    wait_done();
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    xready = ready_fn(cyc);
  end

  // Per-cycle compare against the model, then advance the model to the next cycle.
  initial begin
    int t;
    bit e_cs, e_str, e_done, e_terr;
    forever begin
      @(negedge clk);
      t = m_act ? cyc - m_acc : 0;
      e_cs = 0; e_str = 0; e_done = 0; e_terr = 0;
      if (m_act) begin
        if (t >= 1 && t < m_d) begin
          e_cs  = 1;
          e_str = (t >= L + 1) && (t <= L + A + m_w);
        end else if (t == m_d) begin
          e_done = 1;
          e_terr = m_err;
        end
      end
      if (mon_en) begin
        chk("busy", busy, e_cs);
        chk("xcs_n", xcs_n, !e_cs);
        chk("xwe_n", xwe_n, !(e_str && m_we));
        chk("xrd_n", xrd_n, !(e_str && !m_we));
        chk("done", done, e_done);
        chk("timeout_err", terr, e_terr);
        chk("rdata", rdata, m_rdata);
        if (e_cs) chk("xadd", xadd, m_addr);
        if (e_cs && m_we) chk("xdata_wr", xdata, m_wdata);
        if (e_str && !m_we) chk("xdata_rd", xdata, pdata);
        if (!xcs_n) cs_low++;
        if (!xwe_n) we_low++;
        if (!xrd_n) rd_low++;
        if (done) begin
          if (done_cnt == 0) first_done = cyc;
          done_cnt++;
          done_cyc = cyc;
          done_terr = terr;
          done_rdata = rdata;
        end
      end
      if (rst) begin
        m_act = 0;
        m_rdata = '0;
        m_addr = '0;
      end else begin
        if (m_act && t == L + A + m_w && !m_we && !m_err) m_rdata = pdata;
        if (m_act && t == m_d) m_act = 0;
        if (!m_act && req) begin
          m_act = 1; m_acc = cyc; m_we = req_we; m_addr = req_addr; m_wdata = req_wdata;
          m_w = TO; m_err = 1;
          for (int k = 0; k <= TO; k++) begin
            if (ready_fn(cyc + L + A + k)) begin
              m_w = k; m_err = 0;
              break;
            end
          end
          m_d = L + A + m_w + T + 1;
        end
      end
    end
  end

  initial begin
    rst = 1; req = 0; req_we = 0; req_addr = '0; req_wdata = '0; pdata = '0; xready = 1;
    clear_meas();
    tick();
    mon_en = 1;
    tick();
    rst = 0;
    chk("rst_xcs_n", xcs_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_xadd", xadd, 0);
    chk("rst_rdata", rdata, 0);
    tick();

    // Default write
    do_txn(1, 20'h0FC05, 16'h1234);
    chk("t1_cs_low", cs_low, 7);
    chk("t1_we_low", we_low, 4);
    chk("t1_rd_low", rd_low, 0);
    chk("t1_done_at", done_cyc - acc, 8);
    chk("t1_terr", done_terr, 0);

    // Default read
    pdata = 16'hA5A5;
    do_txn(0, 20'h0FC01, 16'h0);
    chk("t2_rd_low", rd_low, 4);
    chk("t2_we_low", we_low, 0);
    chk("t2_rdata", done_rdata, 16'hA5A5);

    // Read with three wait cycles
    pdata = 16'h3C3C;
    rl_lo = cyc + L + A; rl_hi = cyc + L + A + 3;
    do_txn(0, 20'h00100, 16'h0);
    chk("t3_rd_low", rd_low, 7);
    chk("t3_done_at", done_cyc - acc, 11);
    chk("t3_terr", done_terr, 0);
    chk("t3_rdata", done_rdata, 16'h3C3C);

    // Ready stuck low: timeout
    pdata = 16'hBEEF;
    rl_lo = cyc; rl_hi = cyc + 1000;
    do_txn(0, 20'h00200, 16'h0);
    rl_hi = 0;
    chk("t4_rd_low", rd_low, 20);
    chk("t4_done_at", done_cyc - acc, 24);
    chk("t4_terr", done_terr, 1);
    chk("t4_rdata_kept", done_rdata, 16'h3C3C);
    tick();

    // Reset during the second active cycle of a write
    clear_meas();
    req = 1; req_we = 1; req_addr = 20'h12345; req_wdata = 16'hCAFE;
    acc = cyc;
    tick();
    req = 0;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t5_xcs_n", xcs_n, 1);
    chk("t5_xwe_n", xwe_n, 1);
    chk("t5_busy", busy, 0);
    repeat (10) tick();
    chk("t5_no_done", done_cnt, 0);
    pdata = 16'h1357;
    do_txn(0, 20'h00300, 16'h0);
    chk("t5_rdata", done_rdata, 16'h1357);
    chk("t5_done_at", done_cyc - acc, 8);
    tick();

    // Request held high with mid-transaction toggles and changing address
    clear_meas();
    req_we = 1; req_wdata = 16'h5555;
    for (int i = 0; i < 30; i++) begin
      req = !((i % 8) == 3 || (i % 8) == 5);
      req_addr = 20'h0ABCD + 20'(i);
      tick();
    end
    req = 0;
    repeat (12) tick();
    chk("t6_done_cnt", done_cnt, 4);
    chk("t6_cs_low", cs_low, 28);
    chk("t6_period", done_cyc - first_done, 24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
